// File: rtl/hs_mem_fifo_pkg.sv
// Shared constants and pointer helpers for the SDPRAM-backed FWFT FIFO controller.
package hs_mem_fifo_pkg;

   localparam int OBUF_DEPTH = 2;
   localparam int OBUF_IDX_W = $clog2(OBUF_DEPTH);
   localparam int OBUF_CNT_W = $clog2(OBUF_DEPTH + 1);

   // Pointers carry one extra wrap bit above the aw address bits.
   function automatic logic ptr_full(input logic [31:0] wptr, input logic [31:0] rptr,
                                     input int unsigned aw);
      logic [31:0] mask;
      logic [31:0] diff;
      mask = (32'd1 << (aw + 1)) - 32'd1;
      diff = (wptr ^ rptr) & mask;
      return diff == (32'd1 << aw);
   endfunction

   function automatic logic ptr_empty(input logic [31:0] wptr, input logic [31:0] rptr,
                                      input int unsigned aw);
      logic [31:0] mask;
      mask = (32'd1 << (aw + 1)) - 32'd1;
      return ((wptr ^ rptr) & mask) == 32'd0;
   endfunction

endpackage

// File: rtl/hs_mem_fifo_obuf.sv
// Two-entry order-preserving output buffer that holds the FIFO head ahead of the RAM.
module hs_mem_fifo_obuf
   import hs_mem_fifo_pkg::*;
#(
   parameter type DATA_TYPE = logic [7:0]
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push,
   input  DATA_TYPE              din,
   input  logic                  pop,
   output DATA_TYPE              dout,
   output logic [OBUF_CNT_W-1:0] cnt
);

   DATA_TYPE                mem [OBUF_DEPTH];
   logic [OBUF_IDX_W-1:0]   wr_idx;
   logic [OBUF_IDX_W-1:0]   rd_idx;

   // Push and pop may land on the same edge; they touch different slots so order holds.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_idx <= '0;
         rd_idx <= '0;
         cnt    <= '0;
      end else begin
         if (push) begin
            mem[wr_idx] <= din;
            wr_idx      <= wr_idx + 1'b1;
         end
         if (pop) begin
            rd_idx <= rd_idx + 1'b1;
         end
         cnt <= cnt + OBUF_CNT_W'(push) - OBUF_CNT_W'(pop);
      end
   end

   assign dout = mem[rd_idx];

endmodule

// File: rtl/hs_mem_fifo_sdpram_ctrl.sv
// FWFT FIFO controller driving an external 1W/1R SDPRAM with one cycle of read latency.
// Optional direct-to-buffer path for pushes into an empty FIFO: HS_MEM_FIFO_CTRL_BYPASS_EN.
module hs_mem_fifo_sdpram_ctrl
   import hs_mem_fifo_pkg::*;
#(
   parameter type DATA_TYPE  = logic [7:0],
   parameter int  DATA_DEPTH = 16,
   localparam int ADDR_WIDTH = $clog2(DATA_DEPTH),
   localparam int LVL_WIDTH  = $clog2(DATA_DEPTH + 3)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  s_valid,
   output logic                  s_ready,
   input  DATA_TYPE              s_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output DATA_TYPE              m_data,
   output logic [ADDR_WIDTH-1:0] ram_waddr,
   output DATA_TYPE              ram_wdata,
   output logic                  ram_wen,
   output logic [ADDR_WIDTH-1:0] ram_raddr,
   output logic                  ram_ren,
   input  DATA_TYPE              ram_rdata,
   output logic [LVL_WIDTH-1:0]  level
);

   if (DATA_DEPTH < 2 || (DATA_DEPTH & (DATA_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("hs_mem_fifo_sdpram_ctrl: DATA_DEPTH must be a power of two >= 2");
   end

   logic [ADDR_WIDTH:0]   wptr;
   logic [ADDR_WIDTH:0]   rptr;
   logic [ADDR_WIDTH:0]   ram_cnt;
   logic                  inflight;
   logic                  full;
   logic                  empty;
   logic                  push;
   logic                  pop;
   logic                  byp;
   logic                  obuf_fill;
   DATA_TYPE              obuf_din;
   logic [OBUF_CNT_W-1:0] obuf_cnt;
   logic [2:0]            obuf_need;
   logic [2:0]            obuf_room;

   assign full    = ptr_full(32'(wptr), 32'(rptr), ADDR_WIDTH);
   assign empty   = ptr_empty(32'(wptr), 32'(rptr), ADDR_WIDTH);
   assign ram_cnt = wptr - rptr;

   assign s_ready = !rst && !full;
   assign m_valid = !rst && (obuf_cnt != '0);
   assign push    = s_valid && s_ready;
   assign pop     = m_valid && m_ready;

   // A read is only issued if the buffer can absorb it after this cycle's pop.
   assign obuf_need = 3'(obuf_cnt) + 3'(inflight);
   assign obuf_room = 3'(OBUF_DEPTH) + 3'(pop);

`ifdef HS_MEM_FIFO_CTRL_BYPASS_EN
   assign byp = push && empty && !inflight && (3'(obuf_cnt) < obuf_room);
`else
   assign byp = 1'b0;
`endif

   assign ram_wen   = push && !byp;
   assign ram_waddr = wptr[ADDR_WIDTH-1:0];
   assign ram_wdata = s_data;
   assign ram_ren   = !rst && !empty && (obuf_need < obuf_room);
   assign ram_raddr = rptr[ADDR_WIDTH-1:0];

   // Clearing inflight on reset is what drops read data returning just after reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         wptr     <= '0;
         rptr     <= '0;
         inflight <= 1'b0;
      end else begin
         if (ram_wen) begin
            wptr <= wptr + 1'b1;
         end
         if (ram_ren) begin
            rptr <= rptr + 1'b1;
         end
         inflight <= ram_ren;
      end
   end

   assign obuf_fill = inflight || byp;
   assign obuf_din  = inflight ? ram_rdata : s_data;

   hs_mem_fifo_obuf #(
      .DATA_TYPE(DATA_TYPE)
   ) u_obuf (
      .clk  (clk),
      .rst  (rst),
      .push (obuf_fill),
      .din  (obuf_din),
      .pop  (pop),
      .dout (m_data),
      .cnt  (obuf_cnt)
   );

   assign level = LVL_WIDTH'(ram_cnt) + LVL_WIDTH'(inflight) + LVL_WIDTH'(obuf_cnt);

endmodule

// File: tb/tb_hs_mem_fifo_sdpram_ctrl.sv
// Scoreboard bench for hs_mem_fifo_sdpram_ctrl with a behavioural SDPRAM (read latency 1).
module tb_hs_mem_fifo_sdpram_ctrl;

   localparam int DEPTH = 16;

`ifdef HS_MEM_FIFO_CTRL_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic       sValid;
   logic       sReady;
   logic [7:0] sData;
   logic       mValid;
   logic       mReady;
   logic [7:0] mData;
   logic [3:0] ramWaddr;
   logic [7:0] ramWdata;
   logic       ramWen;
   logic [3:0] ramRaddr;
   logic       ramRen;
   logic [7:0] ramRdata;
   logic [4:0] level;

   logic [7:0] ramMem [DEPTH];
   logic [7:0] sbQ [$];
   int         checkCount = 0;
   int         errorCount = 0;
   int         popCount = 0;
   int         acceptCount = 0;

   always #5 clk = ~clk;

   hs_mem_fifo_sdpram_ctrl #(
      .DATA_TYPE  (logic [7:0]),
      .DATA_DEPTH (DEPTH)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .s_valid   (sValid),
      .s_ready   (sReady),
      .s_data    (sData),
      .m_valid   (mValid),
      .m_ready   (mReady),
      .m_data    (mData),
      .ram_waddr (ramWaddr),
      .ram_wdata (ramWdata),
      .ram_wen   (ramWen),
      .ram_raddr (ramRaddr),
      .ram_ren   (ramRen),
      .ram_rdata (ramRdata),
      .level     (level)
   );

   // Behavioural SDPRAM: write and registered read on the same clock.
   always @(posedge clk) begin
      if (ramWen) ramMem[ramWaddr] <= ramWdata;
      if (ramRen) ramRdata <= ramMem[ramRaddr];
   end

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
      end
   endtask

   // Handshakes are sampled mid-cycle; they complete on the following rising edge.
   always @(negedge clk) begin
      if (rst) begin
         sbQ.delete();
      end else begin
         checkOutput("level", 32'(level), 32'(sbQ.size()));
         if (mValid && mReady) begin
            if (sbQ.size() == 0) checkOutput("popEmptyModel", 32'(mData), 32'hFFFF_FFFF);
            else checkOutput("mData", 32'(mData), 32'(sbQ.pop_front()));
            popCount++;
         end
         if (sValid && sReady) begin
            sbQ.push_back(sData);
            acceptCount++;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic valid, input logic [7:0] data, input logic ready);
      sValid = valid;
      sData  = data;
      mReady = ready;
      step();
   endtask

   task automatic drainAll();
      sValid = 1'b0;
      mReady = 1'b1;
      for (int n = 0; n < 100 && (sbQ.size() != 0 || mValid); n++) step();
      mReady = 1'b0;
      step();
      checkOutput("drainLevel", 32'(level), 32'd0);
      checkOutput("drainValid", 32'(mValid), 32'd0);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int stalls;
      int guard;
      rst = 1'b1; sValid = 1'b0; sData = '0; mReady = 1'b0;
      repeat (3) step();
      checkOutput("rstSReady", 32'(sReady), 32'd0);
      checkOutput("rstMValid", 32'(mValid), 32'd0);
      checkOutput("rstRamRen", 32'(ramRen), 32'd0);
      rst = 1'b0;
      #1;
      checkOutput("postRstLevel", 32'(level), 32'd0);
      checkOutput("postRstSReady", 32'(sReady), 32'd1);

      // Four pushes with the consumer stalled
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'h11 + 8'(i), 1'b0);
      sValid = 1'b0;
      #1;
      checkOutput("fourLevel", 32'(level), 32'd4);
      checkOutput("fourHead", 32'(mData), 32'h11);
      repeat (2) step();
      checkOutput("fourRenIdle", 32'(ramRen), 32'd0);
      checkOutput("fourValid", 32'(mValid), 32'd1);
      drainAll();

      // Fill to capacity: 16 in RAM plus 2 in the output buffer
      acceptCount = 0;
      for (int i = 0; i < 25; i++) applyStimulus(1'b1, 8'h80 + 8'(acceptCount), 1'b0);
      checkOutput("fullAccepted", 32'(acceptCount), 32'd18);
      checkOutput("fullLevel", 32'(level), 32'd18);
      checkOutput("fullSReady", 32'(sReady), 32'd0);
      drainAll();

      // Latency from an empty FIFO
      repeat (2) step();
      applyStimulus(1'b1, 8'hA5, 1'b0);
      sValid = 1'b0;
      #1;
      checkOutput("latK", 32'(mValid), 32'(BYPASS));
      step();
      checkOutput("latK1", 32'(mValid), 32'(BYPASS));
      step();
      checkOutput("latK2", 32'(mValid), 32'd1);
      checkOutput("latData", 32'(mData), 32'hA5);
      drainAll();

      // Streaming: one item per cycle on both sides
      popCount = 0;
      stalls = 0;
      for (int i = 0; i < 100; i++) begin
         if (!sReady) stalls++;
         applyStimulus(1'b1, 8'(i), 1'b1);
      end
      sValid = 1'b0;
      checkOutput("streamStalls", 32'(stalls), 32'd0);
      checkOutput("streamPops", 32'(popCount), BYPASS ? 32'd99 : 32'd97);
      checkOutput("streamLevel", 32'(level), BYPASS ? 32'd1 : 32'd3);
      drainAll();

      // Random valid/ready traffic across several pointer wraps
      acceptCount = 0;
      guard = 0;
      while (acceptCount < 40 && guard < 400) begin
         applyStimulus(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 1)));
         guard++;
      end
      checkOutput("wrapAccepted", 32'(acceptCount >= 40), 32'd1);
      drainAll();

      // Reset with items pending and a read in flight
      for (int i = 0; i < 5; i++) applyStimulus(1'b1, 8'h51 + 8'(i), 1'b0);
      sValid = 1'b1; sData = 8'h66; mReady = 1'b1;
      #1;
      checkOutput("preRstRen", 32'(ramRen), 32'd1);
      step();
      checkOutput("preRstLevel", 32'(level), 32'd5);
      rst = 1'b1; sValid = 1'b0; mReady = 1'b0;
      #1;
      checkOutput("midRstSReady", 32'(sReady), 32'd0);
      checkOutput("midRstWen", 32'(ramWen), 32'd0);
      checkOutput("midRstRen", 32'(ramRen), 32'd0);
      step();
      rst = 1'b0;
      #1;
      checkOutput("afterRstLevel", 32'(level), 32'd0);
      for (int i = 0; i < 3; i++) begin
         checkOutput("afterRstValid", 32'(mValid), 32'd0);
         step();
      end
      checkOutput("afterRstLevel2", 32'(level), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
